nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Serial adder: adds two W-bit operands one 4-bit slice per clock.
// Valid/ready handshakes on the operand input and on the result output.
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   Cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   Sum,
    output logic                   Carry,
    output logic                   busy
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rc_q, rc_d;
    logic            carry_q, carry_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [3:0]      a_sl;
    logic [3:0]      b_sl;
    logic [4:0]      slice;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            rc_q        <= 1'b0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            rc_q        <= rc_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        rc_d    = rc_q;
        carry_d = carry_q;
        a_sl    = 4'd0;
        b_sl    = 4'd0;

        // Select the current slice of each latched operand
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CW'(i)) begin
                a_sl = a_q[4*i +: 4];
                b_sl = b_q[4*i +: 4];
            end
        end
        slice = {1'b0, a_sl} + {1'b0, b_sl} + {4'd0, rc_q};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    rc_d    = Cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (cnt_q == CW'(i)) begin
                        sum_d[4*i +: 4] = slice[3:0];
                    end
                end
                rc_d = slice[4];
                if (cnt_q == CW'(NIBBLES - 1)) begin
                    carry_d = slice[4];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN) || (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign Sum       = sum_q;
    assign Carry     = carry_q;

endmodule
